lbp_stream_engine: RTL and testbench

- Parametrised successor to the fixed 128x128 LBP block: computes the 8-bit Local Binary Pattern of every pixel of an IMG_W x IMG_H grayscale image held in external gray memory.
- Writes results to external LBP memory, one write per pixel.
- Reads each gray pixel exactly once and in raster order. Two line buffers plus a 3x3 window register array replace the 9-reads-per-pixel scheme.
- Sits between the gray image ROM and the LBP result RAM. Handles one frame per reset.

---
 rtl/lbp_stream_engine.sv | 181 ++++++++++++++++++
 tb/tb_lbp_stream_engine.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_stream_engine.sv
// lbp_stream_engine
//   Streams an IMG_W x IMG_H grayscale image out of gray memory once, in
//   raster order, and writes the 8-bit Local Binary Pattern of every pixel
//   to LBP memory (one write per pixel, addresses strictly increasing).
//   Two line buffers plus a 3x3 window hold the neighbourhood, so every
//   gray pixel is read exactly once.
//
// Ports
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   gray_ready   gray memory available
//   gray_req     read request (combinational: READ state and gray_ready)
//   gray_addr    raster index of the requested pixel
//   gray_data    read data, valid in the same cycle as gray_req
//   lbp_valid    registered write strobe for LBP memory
//   lbp_addr     raster index of the result
//   lbp_data     LBP result (0 for border pixels)
//   finish       frame complete, held until reset
//   thresh       compare offset, present only with LBP_THRESH_EN
//
// Build option
//   LBP_THRESH_EN  adds thresh: bit set iff neighbour >= centre + thresh,
//                  sum taken at DATA_W+1 bits so it never wraps.
module lbp_stream_engine #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [DATA_W-1:0] gray_data,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              finish
`ifdef LBP_THRESH_EN
  ,
  input  logic [DATA_W-1:0] thresh
`endif
);

  localparam int N  = IMG_W * IMG_H;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] wr_cnt;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;

  // Window columns c-2 and c-1 (rows r-2, r-1, r); column c is formed
  // combinationally from the line buffers and the incoming pixel.
  logic [DATA_W-1:0] win [0:2][0:1];
  logic [DATA_W-1:0] lb_top [0:IMG_W-1];
  logic [DATA_W-1:0] lb_mid [0:IMG_W-1];

  logic [DATA_W-1:0] top_new, mid_new, gc, thr;
  logic [DATA_W-1:0] nb [0:7];
  logic [DATA_W:0]   thr_sum;
  logic [7:0]        pattern;
  logic              border, emit, last_rd, last_wr;

`ifdef LBP_THRESH_EN
  assign thr = thresh;
`else
  assign thr = '0;
`endif

  assign last_rd = (gray_addr == ADDR_W'(N - 1));
  assign last_wr = (wr_cnt == ADDR_W'(N - 1));

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gray_ready) state_nxt = READ;
      READ:    if (gray_ready && last_rd) state_nxt = DRAIN;
      DRAIN:   if (last_wr) state_nxt = DONE;
      default: state_nxt = DONE;
    endcase
  end

  // FSM outputs
  always_comb begin
    gray_req = (state == READ) && gray_ready;
  end

  // LBP of the centre pixel (row r-1, col c-1) of the window that the
  // incoming pixel completes.
  always_comb begin
    top_new = lb_top[col];
    mid_new = lb_mid[col];
    gc      = win[1][1];
    nb[0]   = win[0][0];
    nb[1]   = win[0][1];
    nb[2]   = top_new;
    nb[3]   = win[1][0];
    nb[4]   = mid_new;
    nb[5]   = win[2][0];
    nb[6]   = win[2][1];
    nb[7]   = gray_data;
    thr_sum = {1'b0, gc} + {1'b0, thr};
    pattern = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      pattern[i] = ({1'b0, nb[i]} >= thr_sum);
    end
    // Centre in row 0, or column 0/IMG_W-1 (incoming col 1/0); the col 0
    // case also covers windows straddling a row wrap.
    border = (row == RW'(1)) || (col < CW'(2));
    // First output appears once input k = IMG_W+1 (row 1, col 1) arrives.
    emit   = (row != '0) && !((row == RW'(1)) && (col == '0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gray_addr <= '0;
      wr_cnt    <= '0;
      col       <= '0;
      row       <= '0;
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
      finish    <= 1'b0;
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 2; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      lbp_valid <= 1'b0;
      finish    <= (state == DONE);
      if (gray_req) begin
        gray_addr <= gray_addr + 1'b1;
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        for (int unsigned r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
        end
        win[0][1] <= top_new;
        win[1][1] <= mid_new;
        win[2][1] <= gray_data;
        if (emit) begin
          lbp_valid <= 1'b1;
          lbp_addr  <= wr_cnt;
          lbp_data  <= border ? 8'h00 : pattern;
          wr_cnt    <= wr_cnt + 1'b1;
        end
      end else if (state == DRAIN) begin
        // Remaining IMG_W+1 pixels all lie on the border.
        lbp_valid <= 1'b1;
        lbp_addr  <= wr_cnt;
        lbp_data  <= '0;
        wr_cnt    <= wr_cnt + 1'b1;
      end
    end
  end

  // Line buffers: lb_top holds row r-2, lb_mid row r-1, indexed by column.
  always_ff @(posedge clk) begin
    if (gray_req) begin
      lb_top[col] <= lb_mid[col];
      lb_mid[col] <= gray_data;
    end
  end

endmodule

// File: tb/tb_lbp_stream_engine.sv
// Directed bench for lbp_stream_engine on a 4x4 image: reset state, IDLE
// wait, three hand-computed images, read stall, mid-frame reset and (with
// LBP_THRESH_EN) the threshold offset.
module tb_lbp_stream_engine;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [7:0]    gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [7:0]    lbp_data;
  logic          finish;
`ifdef LBP_THRESH_EN
  logic [7:0]    thresh = 8'h00;
`endif

  logic [7:0] img     [N];
  logic [7:0] exp_mem [N];
  logic [7:0] lbp_mem [N];
  int rd_log [64];
  int checks = 0;
  int errors = 0;
  int rd_cnt, wr_cnt, order_err, cyc, first_req, fin_cyc, fin_rises;
  logic fin_q;

  always #5 clk = ~clk;

  assign gray_data = img[gray_addr];

  lbp_stream_engine #(.IMG_W(W), .IMG_H(H), .DATA_W(8), .ADDR_W(AW)) dut (
    .clk(clk),
    .reset(reset),
    .gray_ready(gray_ready),
    .gray_req(gray_req),
    .gray_addr(gray_addr),
    .gray_data(gray_data),
    .lbp_valid(lbp_valid),
    .lbp_addr(lbp_addr),
    .lbp_data(lbp_data),
    .finish(finish)
`ifdef LBP_THRESH_EN
    ,
    .thresh(thresh)
`endif
  );

  task automatic mon_clear();
    rd_cnt = 0; wr_cnt = 0; order_err = 0; cyc = 0;
    first_req = -1; fin_cyc = -1;
    for (int i = 0; i < N; i++) lbp_mem[i] = 8'hAA;
  endtask

  // Bus monitor, called once per cycle at the falling edge.
  task automatic sample();
    cyc++;
    if (gray_req === 1'b1) begin
      if (first_req < 0) first_req = cyc;
      if (rd_cnt < 64) rd_log[rd_cnt] = int'(gray_addr);
      rd_cnt++;
    end
    if (lbp_valid === 1'b1) begin
      if (int'(lbp_addr) != wr_cnt) order_err++;
      if (wr_cnt < N) lbp_mem[lbp_addr] = lbp_data;
      wr_cnt++;
    end
    if (finish === 1'b1 && fin_q !== 1'b1) begin
      fin_rises++;
      if (fin_cyc < 0) fin_cyc = cyc;
    end
    fin_q = finish;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    gray_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mon_clear();
    fin_rises = 0;
    fin_q = 1'b0;
  endtask

  task automatic run_frame(input int stall_after, input int stall_len, input int rst_after);
    bit stalled = 0;
    bit rst_done = 0;
    int budget = 0;
    gray_ready = 1'b1;
    while (fin_cyc < 0 && budget < 300) begin
      tick();
      budget++;
      if (stall_after >= 0 && !stalled && rd_cnt == stall_after + 1) begin
        stalled = 1;
        gray_ready = 1'b0;
        for (int j = 0; j < stall_len; j++) begin
          @(negedge clk);
          sample();
          checks++;
          if (gray_req !== 1'b0 || int'(gray_addr) != stall_after + 1 ||
              (j > 0 && lbp_valid !== 1'b0)) begin
            errors++;
            $display("FAIL stall cycle %0d: gray_req=%b gray_addr=%0d lbp_valid=%b, required 0/%0d/0",
                     j, gray_req, gray_addr, lbp_valid, stall_after + 1);
          end
          @(posedge clk);
          #1;
        end
        gray_ready = 1'b1;
      end
      if (rst_after >= 0 && !rst_done && rd_cnt == rst_after + 1) begin
        rst_done = 1;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish} !== '0) begin
          errors++;
          $display("FAIL async_reset: req=%b gaddr=%0d valid=%b laddr=%0d data=%02h fin=%b, required all 0",
                   gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mon_clear();
      end
    end
    checks++;
    if (fin_cyc < 0) begin
      errors++;
      $display("FAIL frame_timeout: finish not seen within %0d cycles, required high", budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    gray_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (gray_req !== 1'b0 || gray_addr !== '0) begin
      errors++;
      $display("FAIL reset_read: gray_req=%b gray_addr=%0d, required 0/0", gray_req, gray_addr);
    end
    checks++;
    if (lbp_valid !== 1'b0 || lbp_addr !== '0 || lbp_data !== 8'h00 || finish !== 1'b0) begin
      errors++;
      $display("FAIL reset_write: valid=%b addr=%0d data=%02h finish=%b, required all 0",
               lbp_valid, lbp_addr, lbp_data, finish);
    end
  endtask

  task automatic test_idle_wait();
    start_frame();
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    checks++;
    if (rd_cnt != 0 || wr_cnt != 0) begin
      errors++;
      $display("FAIL idle_wait: reads=%0d writes=%0d with gray_ready low, required 0/0", rd_cnt, wr_cnt);
    end
  endtask

  task automatic test_index_image();
    for (int i = 0; i < N; i++) img[i] = 8'(i);
    exp_mem = '{default: 8'h00};
    exp_mem[5] = 8'hF0; exp_mem[6] = 8'hF0; exp_mem[9] = 8'hF0; exp_mem[10] = 8'hF0;
    start_frame();
    run_frame(-1, 0, -1);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (lbp_mem[i] !== exp_mem[i]) begin
        errors++;
        $display("FAIL index_mem[%0d]: got %02h, required %02h", i, lbp_mem[i], exp_mem[i]);
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (rd_log[i] != i) begin
        errors++;
        $display("FAIL index_read_seq[%0d]: got %0d, required %0d", i, rd_log[i], i);
      end
    end
    checks++;
    if (rd_cnt != N || wr_cnt != N || order_err != 0) begin
      errors++;
      $display("FAIL index_counts: reads=%0d writes=%0d order_err=%0d, required %0d/%0d/0",
               rd_cnt, wr_cnt, order_err, N, N);
    end
    checks++;
    if (fin_cyc - first_req != N + W + 2) begin
      errors++;
      $display("FAIL index_latency: first gray_req to finish %0d cycles, required %0d",
               fin_cyc - first_req, N + W + 2);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (finish !== 1'b1 || gray_req !== 1'b0 || lbp_valid !== 1'b0 || fin_rises != 1 || wr_cnt != N) begin
      errors++;
      $display("FAIL done_hold: finish=%b req=%b valid=%b rises=%0d writes=%0d, required 1/0/0/1/%0d",
               finish, gray_req, lbp_valid, fin_rises, wr_cnt, N);
    end
  endtask

  task automatic load_crafted();
    img = '{8'd10, 8'd20, 8'd30, 8'd40,
           8'd50, 8'd5,  8'd60, 8'd70,
           8'd0,  8'd90, 8'd100, 8'd1,
           8'd200, 8'd3, 8'd100, 8'd7};
    exp_mem = '{default: 8'h00};
    exp_mem[5] = 8'hDF; exp_mem[6] = 8'h70; exp_mem[9] = 8'hB0; exp_mem[10] = 8'h40;
  endtask

  task automatic test_crafted_image();
    load_crafted();
    start_frame();
    run_frame(-1, 0, -1);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (lbp_mem[i] !== exp_mem[i]) begin
        errors++;
        $display("FAIL crafted_mem[%0d]: got %02h, required %02h", i, lbp_mem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_flat();
    img = '{default: 8'h80};
    exp_mem = '{default: 8'h00};
    exp_mem[5] = 8'hFF; exp_mem[6] = 8'hFF; exp_mem[9] = 8'hFF; exp_mem[10] = 8'hFF;
    start_frame();
    run_frame(-1, 0, -1);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (lbp_mem[i] !== exp_mem[i]) begin
        errors++;
        $display("FAIL flat_mem[%0d]: got %02h, required %02h", i, lbp_mem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_stall();
    load_crafted();
    start_frame();
    run_frame(7, 4, -1);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (lbp_mem[i] !== exp_mem[i] || rd_log[i] != i) begin
        errors++;
        $display("FAIL stall_mem[%0d]: data %02h read %0d, required %02h / %0d",
                 i, lbp_mem[i], rd_log[i], exp_mem[i], i);
      end
    end
    checks++;
    if (rd_cnt != N || wr_cnt != N || order_err != 0) begin
      errors++;
      $display("FAIL stall_counts: reads=%0d writes=%0d order_err=%0d, required %0d/%0d/0",
               rd_cnt, wr_cnt, order_err, N, N);
    end
  endtask

  task automatic test_midframe_reset();
    for (int i = 0; i < N; i++) img[i] = 8'(i);
    exp_mem = '{default: 8'h00};
    exp_mem[5] = 8'hF0; exp_mem[6] = 8'hF0; exp_mem[9] = 8'hF0; exp_mem[10] = 8'hF0;
    start_frame();
    run_frame(-1, 0, 8);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (lbp_mem[i] !== exp_mem[i] || rd_log[i] != i) begin
        errors++;
        $display("FAIL rst_mem[%0d]: data %02h read %0d, required %02h / %0d",
                 i, lbp_mem[i], rd_log[i], exp_mem[i], i);
      end
    end
    checks++;
    if (rd_cnt != N || wr_cnt != N || order_err != 0 || fin_rises != 1) begin
      errors++;
      $display("FAIL rst_counts: reads=%0d writes=%0d order_err=%0d rises=%0d, required %0d/%0d/0/1",
               rd_cnt, wr_cnt, order_err, fin_rises, N, N);
    end
  endtask

`ifdef LBP_THRESH_EN
  task automatic test_thresh();
    logic [7:0] pix [3] = '{8'h80, 8'hFF, 8'h80};
    logic [7:0] th  [3] = '{8'h01, 8'h01, 8'h00};
    logic [7:0] want[3] = '{8'h00, 8'h00, 8'hFF};
    for (int t = 0; t < 3; t++) begin
      img = '{default: pix[t]};
      thresh = th[t];
      start_frame();
      run_frame(-1, 0, -1);
      checks++;
      if (lbp_mem[5] !== want[t] || lbp_mem[10] !== want[t] || lbp_mem[0] !== 8'h00) begin
        errors++;
        $display("FAIL thresh_%0d: pix=%02h thresh=%02h got %02h/%02h/%02h, required %02h/%02h/00",
                 t, pix[t], th[t], lbp_mem[5], lbp_mem[10], lbp_mem[0], want[t], want[t]);
      end
    end
    thresh = 8'h00;
  endtask
`endif

  initial begin
    for (int i = 0; i < N; i++) img[i] = 8'h00;
    test_reset();
    test_idle_wait();
    test_index_image();
    test_crafted_image();
    test_flat();
    test_stall();
    test_midframe_reset();
`ifdef LBP_THRESH_EN
    test_thresh();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
